mult_share_arbiter: RTL and testbench



---
 rtl/mult_arb_pkg.sv | 37 +++
 rtl/mult_4x4_app.sv | 32 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/mult_share_arbiter.sv | 155 +++++++++++++++
 tb/tb_mult_share_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// Error statistics are enabled by MULT_ARB_ERRSTAT_EN.
package mult_arb_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_t;

  function automatic logic [PROD_W-1:0] abs_diff(
    input logic [PROD_W-1:0] x,
    input logic [PROD_W-1:0] y
  );
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] x,
    input logic [CNT_W-1:0] y
  );
    logic [CNT_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[CNT_W] ? CNT_SAT : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/mult_4x4_app.sv
// Approximate 4x4 multiplier built from four 2x2 blocks.
// Each 2x2 block returns 7 instead of 9 for 3*3.
module mult_4x4_app (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  function automatic logic [3:0] m2(
    input logic [1:0] x,
    input logic [1:0] y
  );
    return {1'b0,
            x[1] & y[1],
            (x[1] & y[0]) | (x[0] & y[1]),
            x[0] & y[0]};
  endfunction

  logic [3:0] ll, hl, lh, hh;

  always_comb begin
    ll = m2(a[1:0], b[1:0]);
    hl = m2(a[3:2], b[1:0]);
    lh = m2(a[1:0], b[3:2]);
    hh = m2(a[3:2], b[3:2]);
    p  = 8'(ll)
       + (8'(hl) << 2)
       + (8'(lh) << 2)
       + (8'(hh) << 4);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or
// after ptr, searching upward with wrap-around.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  int              idx;
  logic [ID_W-1:0] idx_c;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    idx_c  = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      idx_c = ID_W'(idx);
      if (!any && req[idx_c]) begin
        any        = 1'b1;
        gnt[idx_c] = 1'b1;
        gnt_id     = idx_c;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one approximate 4x4 multiplier among N_REQ requesters.
// Define MULT_ARB_ERRSTAT_EN to enable err_acc/op_cnt statistics.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [OP_W*N_REQ-1:0]  req_a,
  input  logic [OP_W*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [PROD_W-1:0]      rsp_m,
  output logic                   busy,
  output logic [CNT_W-1:0]       err_acc,
  output logic [CNT_W-1:0]       op_cnt
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  op_t               op_q, op_d;
  logic [PROD_W-1:0] m_q, m_d;

  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_any;
  op_t               op_sel;
  logic [PROD_W-1:0] app_p;
  logic              hs;

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  always_comb begin
    op_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        op_sel.a = op_sel.a | req_a[OP_W*i +: OP_W];
        op_sel.b = op_sel.b | req_b[OP_W*i +: OP_W];
      end
    end
  end

  mult_4x4_app u_mult (
    .a (op_q.a),
    .b (op_q.b),
    .p (app_p)
  );

  assign hs = (state_q == ST_RSP) && rsp_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_d    = op_q;
    m_d     = m_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          state_d = ST_MUL;
          op_d    = op_sel;
          id_d    = gnt_id;
          ptr_d   = (gnt_id == ID_W'(N_REQ - 1))
                  ? '0 : gnt_id + ID_W'(1);
        end
      end
      ST_MUL: begin
        m_d     = app_p;
        state_d = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      m_q     <= m_d;
    end
  end

  // Grants only leave the block while idle: one op in flight.
  assign req_ready = (state_q == ST_IDLE) ? gnt : '0;
  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_id    = id_q;
  assign rsp_m     = m_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef MULT_ARB_ERRSTAT_EN
  logic [PROD_W-1:0] ex_q, ex_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    ex_d  = ex_q;
    err_d = err_q;
    cnt_d = cnt_q;
    if (state_q == ST_MUL) begin
      ex_d = PROD_W'(op_q.a) * PROD_W'(op_q.b);
    end
    if (hs) begin
      err_d = sat_add(err_q, CNT_W'(abs_diff(ex_q, m_q)));
      cnt_d = sat_add(cnt_q, CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_acc = err_q;
  assign op_cnt  = cnt_q;
`else
  logic unused_hs;
  assign unused_hs = hs;
  assign err_acc   = '0;
  assign op_cnt    = '0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed table,
// hand-written corner sequences, full sweep and random traffic.
module tb_mult_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_m;
  logic        busy;
  logic [15:0] err_acc;
  logic [15:0] op_cnt;

  int nvec = 0;
  int nerr = 0;

  mult_share_arbiter #(.N_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_m     (rsp_m),
    .busy      (busy),
    .err_acc   (err_acc),
    .op_cnt    (op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 2x2 block: exact except 3*3 gives 7.
  function automatic int app2(int x, int y);
    return (x == 3 && y == 3) ? 7 : x * y;
  endfunction

  function automatic int approx(int a, int b);
    return app2(a % 4, b % 4)
         + app2(a / 4, b % 4) * 4
         + app2(a % 4, b / 4) * 4
         + app2(a / 4, b / 4) * 16;
  endfunction

  function automatic int absd(int x, int y);
    return (x > y) ? x - y : y - x;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check);
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    if (check) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_m", 32'(rsp_m), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err_acc", 32'(err_acc), 0);
      chk("rst_op_cnt", 32'(op_cnt), 0);
    end
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [15:0] a;
    logic [15:0] b;
    logic        rdy;
    logic [3:0]  e_rdy;
    logic        e_rv;
    logic [1:0]  e_id;
    logic [7:0]  e_m;
    logic        e_busy;
  } vec_t;

  function automatic vec_t mk(logic [3:0] v, logic [15:0] a,
                              logic [15:0] b, logic rdy,
                              logic [3:0] e_rdy, logic e_rv,
                              logic [1:0] e_id, logic [7:0] e_m,
                              logic e_busy);
    vec_t r;
    r.v = v; r.a = a; r.b = b; r.rdy = rdy;
    r.e_rdy = e_rdy; r.e_rv = e_rv; r.e_id = e_id;
    r.e_m = e_m; r.e_busy = e_busy;
    return r;
  endfunction

  vec_t tbl[21];

  initial begin
    logic [7:0] m35, m79, m106;
    int exp_err, exp_op, acc_err;
    int ids[5];
    int cys[5];
    int ms[5];
    int n;
    bit got;
    int ptr_m, age, win, m_id, m_a, m_b;
    bit infl, erv;
    logic [3:0] exp_rdy, gl;

    m35  = 8'(approx(3, 5));
    m79  = 8'(approx(7, 9));
    m106 = 8'(approx(10, 6));

    // single request, then stall with requester 2 waiting
    tbl[0]  = mk(4'b0010, 16'h0030, 16'h0050, 1, 4'b0010, 0, 0, 0, 0);
    tbl[1]  = mk(4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 0, 0, 1);
    tbl[2]  = mk(4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 1, 1, m35, 1);
    tbl[3]  = mk(4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 0, 0, 0);
    tbl[4]  = mk(4'b0001, 16'h0007, 16'h0009, 0, 4'b0001, 0, 0, 0, 0);
    tbl[5]  = mk(4'b0100, 16'h0A00, 16'h0600, 0, 4'b0000, 0, 0, 0, 1);
    for (int i = 6; i < 16; i++)
      tbl[i] = mk(4'b0100, 16'h0A00, 16'h0600, 0, 4'b0000, 1, 0, m79, 1);
    tbl[16] = mk(4'b0100, 16'h0A00, 16'h0600, 1, 4'b0000, 1, 0, m79, 1);
    tbl[17] = mk(4'b0100, 16'h0A00, 16'h0600, 1, 4'b0100, 0, 0, 0, 0);
    tbl[18] = mk(4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 0, 0, 1);
    tbl[19] = mk(4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 1, 2, m106, 1);
    tbl[20] = mk(4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 0, 0, 0);

    do_reset(1);

    for (int i = 0; i < 21; i++) begin
      req_valid = tbl[i].v;
      req_a     = tbl[i].a;
      req_b     = tbl[i].b;
      rsp_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rv));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      if (tbl[i].e_rv) begin
        chk($sformatf("tbl%0d_rsp_id", i), 32'(rsp_id), 32'(tbl[i].e_id));
        chk($sformatf("tbl%0d_rsp_m", i), 32'(rsp_m), 32'(tbl[i].e_m));
      end
      tick();
    end

    // reset asserted while requester 3's op is in MUL
    req_valid = 4'b1000;
    req_a     = 16'hB000;
    req_b     = 16'hC000;
    #1;
    chk("mr_accept", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    chk("mr_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_req_ready", 32'(req_ready), 0);
    chk("mr_rsp_valid", 32'(rsp_valid), 0);
    chk("mr_rsp_id", 32'(rsp_id), 0);
    chk("mr_rsp_m", 32'(rsp_m), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_err_acc", 32'(err_acc), 0);
    chk("mr_op_cnt", 32'(op_cnt), 0);
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("mr_first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    repeat (4) tick();

    // round robin with all requesters valid
    do_reset(0);
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_a[4*i +: 4] = 4'(i + 2);
      req_b[4*i +: 4] = 4'(13 - i);
    end
    rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (rsp_valid && n < 5) begin
        ids[n] = int'(rsp_id);
        cys[n] = c;
        ms[n]  = int'(rsp_m);
        n++;
      end
      tick();
    end
    req_valid = '0;
    chk("rr_count", 32'(n), 5);
    for (int j = 0; j < n; j++) begin
      chk($sformatf("rr_id%0d", j), 32'(ids[j]), 32'(j % 4));
      chk($sformatf("rr_m%0d", j), 32'(ms[j]),
          32'(approx((j % 4) + 2, 13 - (j % 4))));
      if (j > 0)
        chk($sformatf("rr_gap%0d", j), 32'(cys[j] - cys[j-1]), 3);
    end
    repeat (3) tick();

    // full operand sweep through requester 0
    do_reset(0);
    acc_err = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        req_valid = 4'b0001;
        req_a     = 16'(a);
        req_b     = 16'(b);
        rsp_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
          #1;
          if (req_ready[0]) got = 1;
          tick();
        end
        req_valid = '0;
        if (!got) chk("sw_accept_timeout", 0, 1);
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
          #1;
          if (rsp_valid) begin
            got = 1;
            chk($sformatf("sw_m_%0d_%0d", a, b), 32'(rsp_m),
                32'(approx(a, b)));
          end
          tick();
        end
        if (!got) chk("sw_rsp_timeout", 0, 1);
        acc_err = acc_err + absd(a * b, approx(a, b));
        if (acc_err > 65535) acc_err = 65535;
`ifndef MULT_ARB_ERRSTAT_EN
        chk("sw_err_zero", 32'(err_acc), 0);
        chk("sw_cnt_zero", 32'(op_cnt), 0);
`endif
      end
    end
`ifdef MULT_ARB_ERRSTAT_EN
    chk("sw_op_cnt", 32'(op_cnt), 256);
    chk("sw_err_acc", 32'(err_acc), 32'(acc_err));
`endif

    // random traffic against a transaction-level model
    do_reset(0);
    ptr_m = 0; infl = 0; age = 0;
    m_id = 0; m_a = 0; m_b = 0;
    exp_err = 0; exp_op = 0;
    gl = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (gl[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_a[4*i +: 4] = 4'($urandom_range(0, 15));
          req_b[4*i +: 4] = 4'($urandom_range(0, 15));
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_a[4*i +: 4] = 4'($urandom_range(0, 15));
          req_b[4*i +: 4] = 4'($urandom_range(0, 15));
        end else if (req_valid[i] && $urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      win = -1;
      if (!infl) begin
        for (int k = 0; k < 4; k++) begin
          if (win < 0 && req_valid[(ptr_m + k) % 4])
            win = (ptr_m + k) % 4;
        end
      end
      exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0000;
      erv = infl && (age >= 2);
      chk("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(erv));
      chk("rnd_busy", 32'(busy), 32'(infl));
      if (erv) begin
        chk("rnd_rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rnd_rsp_m", 32'(rsp_m), 32'(approx(m_a, m_b)));
      end
`ifdef MULT_ARB_ERRSTAT_EN
      chk("rnd_err_acc", 32'(err_acc), 32'(exp_err));
      chk("rnd_op_cnt", 32'(op_cnt), 32'(exp_op));
`else
      chk("rnd_err_acc", 32'(err_acc), 0);
      chk("rnd_op_cnt", 32'(op_cnt), 0);
`endif
      gl = exp_rdy;
      if (erv && rsp_ready) begin
        infl = 0;
        exp_op = (exp_op < 65535) ? exp_op + 1 : 65535;
        exp_err = exp_err + absd(m_a * m_b, approx(m_a, m_b));
        if (exp_err > 65535) exp_err = 65535;
      end else if (infl) begin
        age++;
      end
      if (win >= 0) begin
        infl  = 1;
        age   = 1;
        ptr_m = (win + 1) % 4;
        m_id  = win;
        m_a   = int'(req_a[4*win +: 4]);
        m_b   = int'(req_b[4*win +: 4]);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
